// File: rtl/dmem_bridge_if.sv
// External 32-bit word-addressed RAM/peripheral port with req/ack wait states.
// The bridge drives it as master; the RAM or peripheral responds as slave.
interface dmem_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_bridge.sv
// Bridges the pipeline's 64-bit data-memory port to a 32-bit req/ack RAM port:
// splits 64-bit accesses into two beats, steers byte lanes, flags bad or timed-out accesses.
module dmem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   dmem_addr,
    input  logic [63:0]   dmem_dout,
    output logic [63:0]   dmem_din,
    input  logic [1:0]    dmem_write_width,
    input  logic          dmem_rstrobe,
    input  logic          dmem_wstrobe,
    output logic          dmem_cycle_complete,
    output logic          dmem_err,
    output logic          busy,
    dmem_bridge_if.master mem
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_data;
    logic [1:0]        r_width;
    logic              r_we;
    logic              r_err;
    logic [31:0]       r_rd0;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_start;
    logic              w_misalign;
    logic              w_range;
    logic              w_bad;
    logic              w_tmo;
    logic              w_fail;
    logic [3:0]        w_mask;
    logic [31:0]       w_rshift;
    logic [63:0]       w_narrow;
    logic [ADDR_W-3:0] w_waddr;

    assign w_start  = dmem_rstrobe | dmem_wstrobe;
    assign w_range  = |(dmem_addr >> ADDR_W);
    assign w_bad    = (dmem_rstrobe & dmem_wstrobe) | w_misalign | w_range;
    assign w_tmo    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_waddr  = r_addr[ADDR_W-1:2];
    assign w_rshift = mem.mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_misalign = 1'b0;
        w_mask     = 4'b1111;
        w_narrow   = {32'b0, w_rshift};
        case (dmem_write_width)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = dmem_addr[0];
            2'd2:    w_misalign = |dmem_addr[1:0];
            default: w_misalign = |dmem_addr[2:0];
        endcase
        case (r_width)
            2'd0: begin
                w_mask   = 4'b0001;
                w_narrow = {56'b0, w_rshift[7:0]};
            end
            2'd1: begin
                w_mask   = 4'b0011;
                w_narrow = {48'b0, w_rshift[15:0]};
            end
            default: begin
                w_mask   = 4'b1111;
                w_narrow = {32'b0, w_rshift};
            end
        endcase
    end

    // Ack wins over timeout in the same cycle, so a beat acked on its last allowed cycle succeeds.
    always_comb begin
        w_next        = r_state;
        w_fail        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = '0;
        mem.mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = w_bad ? S_RESP : S_BEAT0;
                    w_fail = w_bad;
                end
            end
            S_BEAT0: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = r_we;
                mem.mem_addr = w_waddr;
                if (r_width == 2'd3) begin
                    mem.mem_be    = 4'hF;
                    mem.mem_wdata = r_data[31:0];
                end else begin
                    mem.mem_be    = w_mask << r_addr[1:0];
                    mem.mem_wdata = r_data[31:0] << {r_addr[1:0], 3'b000};
                end
                if (mem.mem_ack) begin
                    w_next = (r_width == 2'd3) ? S_BEAT1 : S_RESP;
                end else if (w_tmo) begin
                    w_next = S_RESP;
                    w_fail = 1'b1;
                end
            end
            S_BEAT1: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = r_we;
                mem.mem_addr  = w_waddr + (ADDR_W-2)'(1);
                mem.mem_be    = 4'hF;
                mem.mem_wdata = r_data[63:32];
                if (mem.mem_ack) begin
                    w_next = S_RESP;
                end else if (w_tmo) begin
                    w_next = S_RESP;
                    w_fail = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_width  <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_rd0    <= '0;
            r_cnt    <= '0;
            dmem_din <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_start) begin
                r_addr  <= dmem_addr[ADDR_W-1:0];
                r_data  <= dmem_dout;
                r_width <= dmem_write_width;
                r_we    <= dmem_wstrobe;
            end
            if (w_next == S_RESP && r_state != S_RESP) begin
                r_err <= w_fail;
            end
            if (r_state == S_IDLE || (r_state == S_BEAT0 && mem.mem_ack)) begin
                r_cnt <= '0;
            end else if (mem.mem_req && !mem.mem_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Load data reaches the pipeline only on successful reads, at RESP entry.
            if (r_state == S_BEAT0 && mem.mem_ack) begin
                r_rd0 <= mem.mem_rdata;
                if (!r_we && r_width != 2'd3) begin
                    dmem_din <= w_narrow;
                end
            end
            if (r_state == S_BEAT1 && mem.mem_ack && !r_we) begin
                dmem_din <= {mem.mem_rdata, r_rd0};
            end
        end
    end

    assign dmem_cycle_complete = (r_state == S_RESP);
    assign dmem_err            = (r_state == S_RESP) & r_err;
    assign busy                = (r_state != S_IDLE);
endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed scenarios plus randomized accesses checked against a
// byte-array memory model, with a wait-state RAM slave on the external port.
`timescale 1ns/1ps
module tb_dmem_bridge;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_dout;
    logic [63:0] dmem_din;
    logic [1:0]  dmem_write_width;
    logic        dmem_rstrobe;
    logic        dmem_wstrobe;
    logic        dmem_cycle_complete;
    logic        dmem_err;
    logic        busy;

    always #5 clk = ~clk;

    dmem_bridge_if #(.ADDR_W(32)) mem_if ();

    dmem_bridge #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .dmem_addr           (dmem_addr),
        .dmem_dout           (dmem_dout),
        .dmem_din            (dmem_din),
        .dmem_write_width    (dmem_write_width),
        .dmem_rstrobe        (dmem_rstrobe),
        .dmem_wstrobe        (dmem_wstrobe),
        .dmem_cycle_complete (dmem_cycle_complete),
        .dmem_err            (dmem_err),
        .busy                (busy),
        .mem                 (mem_if)
    );

    int          wait_cfg = 0;
    bit          ack_en   = 1'b1;
    bit          poke_en  = 1'b0;
    int          poke_a   = 0;
    logic [31:0] poke_d   = '0;

    logic [31:0] ram [0:255];
    bit          ram_ready  = 1'b0;
    int          wcnt       = 0;
    bit          ack_now    = 1'b0;
    int          req_cycles = 0;
    logic [29:0] lg_a [$];
    logic [31:0] lg_d [$];
    logic [3:0]  lg_be [$];

    logic [7:0]  ref_b [0:1023];
    logic [63:0] exp_din;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] init_word(input int i);
        return (32'h9E3779B9 * (i + 1)) ^ 32'h5A5A0F0F;
    endfunction

    // RAM slave: acks after wait_cfg stalled cycles per beat, writes lanes on the ack cycle.
    always @(negedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] = init_word(i);
            mem_if.mem_rdata = '0;
            ram_ready = 1'b1;
        end
        if (poke_en) ram[poke_a] = poke_d;
        if (ack_now || !mem_if.mem_req) wcnt = 0;
        ack_now = 1'b0;
        if (mem_if.mem_req) begin
            req_cycles++;
            if (ack_en && wcnt >= wait_cfg) begin
                ack_now = 1'b1;
                mem_if.mem_rdata = ram[mem_if.mem_addr[7:0]];
                if (mem_if.mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_if.mem_be[b]) ram[mem_if.mem_addr[7:0]][8*b +: 8] = mem_if.mem_wdata[8*b +: 8];
                end
                lg_a.push_back(mem_if.mem_addr);
                lg_d.push_back(mem_if.mem_wdata);
                lg_be.push_back(mem_if.mem_be);
            end else begin
                wcnt++;
            end
        end
        mem_if.mem_ack = ack_now;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int widx, input logic [31:0] v);
        poke_a  = widx;
        poke_d  = v;
        poke_en = 1'b1;
        @(negedge clk);
        #1 poke_en = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[widx*4 + k] = v[8*k +: 8];
    endtask

    // One access: expected outcome, latency and req cycles follow from width, address and waits.
    task automatic do_acc(input bit wr, input bit both, input logic [1:0] wd,
                          input logic [63:0] a, input logic [63:0] d, input int w);
        int nb, beats, exp_req, exp_cyc, cyc, req0;
        bit is_bad, ok, done;
        logic [63:0] v;
        nb      = 1 << wd;
        is_bad  = both || ((a & 64'(nb - 1)) != 0) || (a[63:32] != 0);
        beats   = (wd == 2'd3) ? 2 : 1;
        ok      = !is_bad && (w < TMO);
        exp_req = is_bad ? 0 : (ok ? beats * (w + 1) : TMO);
        exp_cyc = exp_req + 1;
        req0    = req_cycles;
        wait_cfg         = w;
        dmem_addr        = a;
        dmem_dout        = d;
        dmem_write_width = wd;
        dmem_wstrobe     = wr | both;
        dmem_rstrobe     = !wr | both;
        @(posedge clk);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            dmem_wstrobe = 1'b0;
            dmem_rstrobe = 1'b0;
            if (dmem_cycle_complete) done = 1'b1;
        end
        chk("complete_seen", 64'(done), 64'd1);
        chk("latency", 64'(cyc), 64'(exp_cyc));
        chk("err", 64'(dmem_err), 64'(!ok));
        chk("req_cycles", 64'(req_cycles - req0), 64'(exp_req));
        if (ok && wr) begin
            for (int i = 0; i < nb; i++) ref_b[int'(a[9:0]) + i] = d[8*i +: 8];
        end
        if (ok && !wr) begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[int'(a[9:0]) + i];
            exp_din = v;
        end
        chk("din", dmem_din, exp_din);
        @(negedge clk);
        chk("idle_after", 64'(busy), 64'd0);
        chk("complete_pulse", 64'(dmem_cycle_complete), 64'd0);
    endtask

    initial begin
        int n0;
        dmem_addr        = '0;
        dmem_dout        = '0;
        dmem_write_width = '0;
        dmem_rstrobe     = 1'b0;
        dmem_wstrobe     = 1'b0;
        exp_din          = '0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 4; k++) ref_b[i*4 + k] = init_word(i) >> (8*k);
        end

        repeat (3) @(negedge clk);
        chk("rst_din", dmem_din, 64'd0);
        chk("rst_complete", 64'(dmem_cycle_complete), 64'd0);
        chk("rst_err", 64'(dmem_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'(mem_if.mem_req), 64'd0);
        chk("rst_we", 64'(mem_if.mem_we), 64'd0);
        chk("rst_addr", 64'(mem_if.mem_addr), 64'd0);
        chk("rst_be", 64'(mem_if.mem_be), 64'd0);
        chk("rst_wdata", 64'(mem_if.mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);

        poke(32'h40, 32'hDEADBEEF);
        do_acc(1'b0, 1'b0, 2'd2, 64'h100, 64'd0, 0);
        chk("rd32_din", dmem_din, 64'hDEADBEEF);

        n0 = lg_a.size();
        do_acc(1'b1, 1'b0, 2'd3, 64'h208, 64'h1122334455667788, 3);
        chk("wr64_b0_addr", 64'(lg_a[n0]), 64'h82);
        chk("wr64_b0_data", 64'(lg_d[n0]), 64'h55667788);
        chk("wr64_b0_be", 64'(lg_be[n0]), 64'hF);
        chk("wr64_b1_addr", 64'(lg_a[n0+1]), 64'h83);
        chk("wr64_b1_data", 64'(lg_d[n0+1]), 64'h11223344);
        chk("wr64_b1_be", 64'(lg_be[n0+1]), 64'hF);
        do_acc(1'b0, 1'b0, 2'd3, 64'h208, 64'd0, 1);
        chk("rd64_back", dmem_din, 64'h1122334455667788);

        poke(32'h40, 32'hAABBCCDD);
        n0 = lg_a.size();
        do_acc(1'b0, 1'b0, 2'd0, 64'h103, 64'd0, 0);
        chk("rd8_be", 64'(lg_be[n0]), 64'b1000);
        chk("rd8_din", dmem_din, 64'hAA);

        do_acc(1'b1, 1'b0, 2'd1, 64'h101, 64'hBEEF, 0);
        do_acc(1'b0, 1'b0, 2'd3, 64'h104, 64'd0, 0);
        do_acc(1'b0, 1'b0, 2'd2, 64'h1_0000_0100, 64'd0, 0);
        do_acc(1'b1, 1'b1, 2'd2, 64'h100, 64'h1234, 0);
        chk("err_din_held", dmem_din, 64'hAA);

        do_acc(1'b0, 1'b0, 2'd2, 64'h100, 64'd0, 100);
        do_acc(1'b0, 1'b0, 2'd2, 64'h100, 64'd0, 1);
        chk("after_tmo_din", dmem_din, 64'hAABBCCDD);

        for (int n = 0; n < 80; n++) begin
            logic [1:0]  wd;
            logic [63:0] a, d;
            bit          wr, both;
            int          w, bi;
            wd = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, 1023));
            a  = (a >> wd) << wd;
            if ($urandom_range(0, 5) == 0) a = a | 64'($urandom_range(1, 7));
            if ($urandom_range(0, 15) == 0) begin
                bi = 32 + int'($urandom_range(0, 31));
                a[bi] = 1'b1;
            end
            both = ($urandom_range(0, 15) == 0);
            wr   = 1'($urandom_range(0, 1));
            w    = int'($urandom_range(0, 4));
            d    = {$urandom, $urandom};
            do_acc(wr, both, wd, a, d, w);
        end

        // Reset while the second beat of a 64-bit read is stalled.
        wait_cfg         = 0;
        ack_en           = 1'b1;
        dmem_addr        = 64'h300;
        dmem_write_width = 2'd3;
        dmem_rstrobe     = 1'b1;
        @(posedge clk);
        #1 dmem_rstrobe = 1'b0;
        @(posedge clk);
        #1 ack_en = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_req_b1", 64'(mem_if.mem_req), 64'd1);
        chk("abort_addr_b1", 64'(mem_if.mem_addr), 64'hC1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req_async", 64'(mem_if.mem_req), 64'd0);
        chk("abort_complete", 64'(dmem_cycle_complete), 64'd0);
        repeat (2) @(posedge clk);
        #1 chk("abort_hold_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ack_en  = 1'b1;
        exp_din = '0;
        chk("abort_din_reset", dmem_din, 64'd0);
        @(negedge clk);
        chk("abort_no_complete", 64'(dmem_cycle_complete), 64'd0);
        do_acc(1'b0, 1'b0, 2'd3, 64'h300, 64'd0, 0);
        do_acc(1'b0, 1'b0, 2'd1, 64'h102, 64'd0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
